// File: rtl/comparator_pkg.sv
// Shared types and result encoding for the serial magnitude comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-hot {lt, eq, gt}; NONE is the reset value only.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  function automatic logic [2:0] res_encode(input logic is_lt, input logic is_gt);
    if (is_lt)      return RES_LT;
    else if (is_gt) return RES_GT;
    else            return RES_EQ;
  endfunction

endpackage

// File: rtl/comparator_serial_cmp_chunk.sv
// Combinational unsigned magnitude compare of one operand slice.
module cmp_chunk #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/comparator_serial.sv
// Multi-cycle comparator: walks the operands CHUNK bits per cycle, MSB slice first,
// with a fixed latency of WIDTH/CHUNK cycles regardless of where they differ.
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || WIDTH > 64 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("comparator_serial: WIDTH must be 2..64 and a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             dlt_q, dlt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       res_q, res_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic             slice_lt, slice_gt;

  assign a_sh = a_q >> (32'(cnt_q) * CHUNK);
  assign b_sh = b_q >> (32'(cnt_q) * CHUNK);

  cmp_chunk #(.W(CHUNK)) u_cmp_chunk (
    .a  (a_sh[CHUNK-1:0]),
    .b  (b_sh[CHUNK-1:0]),
    .lt (slice_lt),
    .gt (slice_gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    dlt_d   = dlt_q;
    res_d   = res_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d     = a ^ (signed_mode ? MSB_MASK : '0);
          b_d     = b ^ (signed_mode ? MSB_MASK : '0);
          dec_d   = 1'b0;
          dlt_d   = 1'b0;
          cnt_d   = CW'(NCH - 1);
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!dec_q && (slice_lt || slice_gt)) begin
          dec_d = 1'b1;
          dlt_d = slice_lt;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          res_d   = dec_q ? (dlt_q ? RES_LT : RES_GT) : res_encode(slice_lt, slice_gt);
        end else begin
          cnt_d  = cnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      dlt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      dlt_q   <= dlt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = res_q[2];
  assign eq   = res_q[1];
  assign gt   = res_q[0];

endmodule

// File: tb/tb_comparator_serial.sv
// Bench for comparator_serial: an 8-bit/2-bit-chunk and a 16-bit/4-bit-chunk instance
// checked against a scoreboard of expected results from a behavioural model.
module tb_comparator_serial;

  localparam logic [2:0] E_LT = 3'b100;
  localparam logic [2:0] E_EQ = 3'b010;
  localparam logic [2:0] E_GT = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0, sm = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        busy8, done8, lt8, eq8, gt8;
  logic        busy16, done16, lt16, eq16, gt16;
  logic        sel16 = 1'b0;
  logic        s_busy, s_done;
  logic [2:0]  s_res;

  always #5 clk = ~clk;

  comparator_serial #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm),
    .a(a_in[7:0]), .b(b_in[7:0]),
    .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8)
  );

  comparator_serial #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm),
    .a(a_in), .b(b_in),
    .busy(busy16), .done(done16), .lt(lt16), .eq(eq16), .gt(gt16)
  );

  always_comb begin
    s_busy = sel16 ? busy16 : busy8;
    s_done = sel16 ? done16 : done8;
    s_res  = sel16 ? {lt16, eq16, gt16} : {lt8, eq8, gt8};
  end

  typedef struct {
    logic        w16;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  exp;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  exp;
  } sb_t;

  sb_t sbq[$];
  int  n_pass = 0;
  int  n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [2:0] model(input logic w16, input logic [15:0] a, input logic [15:0] b,
                                       input logic s);
    logic signed [16:0] xa, xb;
    if (w16) begin
      xa = s ? {a[15], a} : {1'b0, a};
      xb = s ? {b[15], b} : {1'b0, b};
    end else begin
      xa = s ? {{9{a[7]}}, a[7:0]} : {9'b0, a[7:0]};
      xb = s ? {{9{b[7]}}, b[7:0]} : {9'b0, b[7:0]};
    end
    if (xa < xb)      return E_LT;
    else if (xa > xb) return E_GT;
    else              return E_EQ;
  endfunction

  // Drive a start pulse at a negedge; the following posedge captures it.
  task automatic launch(input logic w16, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [2:0] exp);
    @(negedge clk);
    sel16 = w16;
    a_in  = a;
    b_in  = b;
    sm    = s;
    if (w16) start16 = 1'b1;
    else     start8  = 1'b1;
    sbq.push_back('{a: a, b: b, sm: s, exp: exp});
  endtask

  // Drop start and scramble the operand inputs after capture.
  task automatic release_start();
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    a_in    = 16'($urandom);
    b_in    = 16'($urandom);
    sm      = ~sm;
  endtask

  task automatic wait_result(input string tag, input int exp_busy);
    int  nb;
    bit  ok;
    sb_t e;
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_done) begin
        ok = 1'b1;
        break;
      end
      if (s_busy) nb++;
      @(negedge clk);
    end
    check({tag, " done_seen"}, 32'(ok), 32'd1);
    check({tag, " busy_cycles"}, 32'(nb), 32'(exp_busy));
    if (sbq.size() == 0) begin
      check({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, " result"}, 32'(s_res), 32'(e.exp));
      $display("txn %s: a=%h b=%h signed=%0b busy=%0d {lt,eq,gt}=%b exp=%b",
               tag, e.a, e.b, e.sm, nb, s_res, e.exp);
    end
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    launch(v.w16, v.a, v.b, v.sm, v.exp);
    release_start();
    wait_result(tag, v.w16 ? 4 : 4);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(s_done), 32'd0);
    check({tag, " hold"}, 32'(s_res), 32'(v.exp));
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{w16: 1'b0, a: 16'h0065, b: 16'h0072, sm: 1'b0, exp: E_LT};
    vecs[1]  = '{w16: 1'b0, a: 16'h0080, b: 16'h007F, sm: 1'b1, exp: E_LT};
    vecs[2]  = '{w16: 1'b0, a: 16'h0080, b: 16'h007F, sm: 1'b0, exp: E_GT};
    vecs[3]  = '{w16: 1'b0, a: 16'h00A5, b: 16'h00A5, sm: 1'b0, exp: E_EQ};
    vecs[4]  = '{w16: 1'b0, a: 16'h00FF, b: 16'h0001, sm: 1'b1, exp: E_LT};
    vecs[5]  = '{w16: 1'b0, a: 16'h00FF, b: 16'h0001, sm: 1'b0, exp: E_GT};
    vecs[6]  = '{w16: 1'b0, a: 16'h0000, b: 16'h00FF, sm: 1'b1, exp: E_GT};
    vecs[7]  = '{w16: 1'b0, a: 16'h0001, b: 16'h0002, sm: 1'b0, exp: E_LT};
    vecs[8]  = '{w16: 1'b0, a: 16'h003C, b: 16'h003C, sm: 1'b1, exp: E_EQ};
    vecs[9]  = '{w16: 1'b1, a: 16'h1234, b: 16'h1235, sm: 1'b0, exp: E_LT};
    vecs[10] = '{w16: 1'b1, a: 16'hFFFF, b: 16'h0001, sm: 1'b1, exp: E_LT};
    vecs[11] = '{w16: 1'b1, a: 16'h8000, b: 16'h7FFF, sm: 1'b0, exp: E_GT};
    vecs[12] = '{w16: 1'b1, a: 16'hABCD, b: 16'hABCD, sm: 1'b1, exp: E_EQ};
    vecs[13] = '{w16: 1'b1, a: 16'h7FFF, b: 16'h8000, sm: 1'b1, exp: E_GT};

    // Reset state, sampled while rst_n is low.
    #12;
    check("reset busy8/done8", {busy8, done8}, 2'b00);
    check("reset res8", {lt8, eq8, gt8}, 3'b000);
    check("reset res16", {busy16, done16, lt16, eq16, gt16}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 10; i++) begin
      vec_t r;
      r.w16 = i[0];
      r.a   = 16'($urandom);
      r.b   = (i % 3 == 0) ? r.a ^ 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
      r.sm  = 1'($urandom);
      r.exp = model(r.w16, r.a, r.b, r.sm);
      do_txn($sformatf("rand%0d", i), r);
    end

    // Back-to-back: restart in the DONE cycle.
    launch(1'b0, 16'h00A5, 16'h00A5, 1'b0, E_EQ);
    release_start();
    wait_result("b2b_first", 4);
    a_in   = 16'h0080;
    b_in   = 16'h007F;
    sm     = 1'b1;
    start8 = 1'b1;
    sbq.push_back('{a: 16'h0080, b: 16'h007F, sm: 1'b1, exp: E_LT});
    @(negedge clk);
    start8 = 1'b0;
    check("b2b done_cleared", 32'(s_done), 32'd0);
    check("b2b busy_again", 32'(s_busy), 32'd1);
    check("b2b hold_old", 32'(s_res), 32'(E_EQ));
    wait_result("b2b_second", 4);

    // start with new operands mid-RUN must be ignored.
    launch(1'b0, 16'h0010, 16'h0020, 1'b0, E_LT);
    release_start();
    @(negedge clk);
    a_in   = 16'h0020;
    b_in   = 16'h0010;
    sm     = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_result("midrun_start", 2);

    // Asynchronous reset in the middle of RUN.
    launch(1'b0, 16'h00C3, 16'h0011, 1'b0, E_GT);
    release_start();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst busy/done", {busy8, done8}, 2'b00);
    check("async_rst res", {lt8, eq8, gt8}, 3'b000);
    void'(sbq.pop_back());
    $display("txn async_rst: busy=%0b done=%0b {lt,eq,gt}=%b", busy8, done8, {lt8, eq8, gt8});
    @(negedge clk);
    rst_n  = 1'b1;
    a_in   = 16'h0065;
    b_in   = 16'h0072;
    sm     = 1'b0;
    start8 = 1'b1;
    sbq.push_back('{a: 16'h0065, b: 16'h0072, sm: 1'b0, exp: E_LT});
    @(negedge clk);
    start8 = 1'b0;
    wait_result("post_reset_start", 4);

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
